// File: rtl/md_pkg.sv
// Shared encodings and defaults for the multiply/divide scheduler.
// Latency: n/a (types, constants and pure decode helpers only).
// Backpressure: n/a.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    function automatic logic md_is_mul(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_signed(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 64-bit product, quotient and remainder for mult/multu/div/divu.
// Latency: zero cycles (pure combinational).
// Backpressure: none; outputs follow inputs, the controller decides when to latch.
module md_arith
    import md_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [63:0] o_prod,
    output logic [31:0] o_quot,
    output logic [31:0] o_rem,
    output logic        o_div_zero
);

    logic        w_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_div_b;
    logic [31:0] w_uquot;
    logic [31:0] w_urem;

    // Signed ops work on magnitudes so no signed divide (and its INT_MIN/-1 overflow) is ever built.
    always_comb begin
        w_signed   = md_is_signed(i_op);
        w_a_neg    = w_signed & i_a[31];
        w_b_neg    = w_signed & i_b[31];

        // Sign-extending to 64 bits lets one unsigned multiplier serve both flavours.
        w_ext_a    = w_signed ? {{32{i_a[31]}}, i_a} : {32'd0, i_a};
        w_ext_b    = w_signed ? {{32{i_b[31]}}, i_b} : {32'd0, i_b};
        o_prod     = w_ext_a * w_ext_b;

        w_mag_a    = w_a_neg ? (~i_a + 32'd1) : i_a;
        w_mag_b    = w_b_neg ? (~i_b + 32'd1) : i_b;
        o_div_zero = (i_b == 32'd0);
        // Substitute divisor keeps the divider defined; the result is discarded on zero.
        w_div_b    = o_div_zero ? 32'd1 : w_mag_b;
        w_uquot    = w_mag_a / w_div_b;
        w_urem     = w_mag_a % w_div_b;

        // Quotient truncates toward zero; remainder takes the dividend's sign.
        o_quot     = (w_a_neg ^ w_b_neg) ? (~w_uquot + 32'd1) : w_uquot;
        o_rem      = w_a_neg ? (~w_urem + 32'd1) : w_urem;
    end

endmodule

// File: rtl/md_ctrl.sv
// HI/LO owner and multi-cycle mult/div scheduler with a busy counter and stall request.
// Latency: mult N=MULT_CYCLES, div N=DIV_CYCLES (commit at edge ending T+N); mthi/mtlo 1 edge.
// Backpressure: stall_req = md_use & busy holds D/E; start is ignored while an op is in flight.
module md_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic        md_use,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    md_state_e          r_state;
    logic               r_busy;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_pend_hi;
    logic [31:0]        r_pend_lo;
    logic               r_pend_wr;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic [63:0]        w_prod;
    logic [31:0]        w_quot;
    logic [31:0]        w_rem;
    logic               w_div_zero;

    md_arith u_arith (
        .i_op       (md_op),
        .i_a        (opa),
        .i_b        (opb),
        .o_prod     (w_prod),
        .o_quot     (w_quot),
        .o_rem      (w_rem),
        .o_div_zero (w_div_zero)
    );

    // Result is computed at start and parked; the counter only models the unit's latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= MD_IDLE;
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_wr <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (start) begin
                        if (md_is_mul(md_op)) begin
                            r_pend_hi <= w_prod[63:32];
                            r_pend_lo <= w_prod[31:0];
                            r_pend_wr <= 1'b1;
                            r_cnt     <= CNT_W'(MULT_CYCLES);
                            r_busy    <= 1'b1;
                            r_state   <= MD_RUN;
                        end else if (md_is_div(md_op)) begin
                            r_pend_hi <= w_rem;
                            r_pend_lo <= w_quot;
                            // Divide by zero still burns the full busy period but commits nothing.
                            r_pend_wr <= ~w_div_zero;
                            r_cnt     <= CNT_W'(DIV_CYCLES);
                            r_busy    <= 1'b1;
                            r_state   <= MD_RUN;
                        end else if (md_op == MD_MTHI) begin
                            r_hi <= opa;
                        end else if (md_op == MD_MTLO) begin
                            r_lo <= opa;
                        end
                    end
                end
                MD_RUN: begin
                    if (r_cnt == CNT_W'(1)) begin
                        if (r_pend_wr) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= MD_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= MD_IDLE;
                end
            endcase
        end
    end

    // The start instruction itself is never stalled, so there is no loop through start.
    assign stall_req = md_use & r_busy;
    assign busy      = r_busy;
    assign hi        = r_hi;
    assign lo        = r_lo;

endmodule
